axi_slave_mem: RTL

AXI3-style slave endpoint holding a word-addressed internal memory. It sits directly downstream of the testbench AXI interface as the DUT that the master BFM drives. It accepts write bursts (AW/W/B) and read bursts (AR/R) on independent single-outstanding channels, applies byte strobes, and returns OKAY or SLVERR responses.

---
 rtl/axi_slave_mem_if.sv | 59 +++++
 rtl/axi_slave_mem.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_if.sv
// rtl/axi_slave_mem_if.sv - AXI3-style write/read channel bundle between master BFM and axi_slave_mem
interface axi_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic                  bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wid, wdata, wstrb, wlast, input wready,
        input  bvalid, bid, bresp, output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rid, rdata, rlast, rresp, output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rlast, rresp, input rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3-style slave memory, single-outstanding write and read bursts
// WRAP bursts are honoured only when AXI_SLV_WRAP_EN is defined; otherwise WRAP is reserved.
module axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic           aclk,
    input  logic           aresetn,
    axi_slave_mem_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
`ifdef AXI_SLV_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Wrap arithmetic is always computed; WRAP legality alone decides whether it is used.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst,
                                                        input logic [3:0] len);
        logic [ADDR_WIDTH-1:0] step, incr, span, base;
        step = ONE << size;
        incr = addr + step;
        span = step * (ADDR_WIDTH'(len) + ONE);
        base = addr & ~(span - ONE);
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (burst == BURST_WRAP && incr == base + span)
            next_addr = base;
        else
            next_addr = incr;
    endfunction

    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [3:0] len);
        burst_bad = (int'(size) > LSB) || (burst == BURST_RSVD)
                 || (burst == BURST_WRAP &&
                     (!WRAP_EN || !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = addr[LSB+IDX_W-1:LSB];
    endfunction

    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [3:0]            aw_len, w_beat;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  w_err, w_beat_err, aw_hs, w_hs, b_hs, mem_we;

    assign aw_hs      = bus.awvalid && bus.awready;
    assign w_hs       = bus.wvalid && bus.wready;
    assign b_hs       = bus.bvalid && bus.bready;
    assign w_beat_err = burst_bad(aw_size, aw_burst, aw_len) || (w_addr >= MEM_BYTES)
                     || (bus.wid != aw_id) || (bus.wlast != (w_beat == aw_len));
    assign mem_we     = w_hs && !w_beat_err;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_beat == aw_len) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bid     <= '0;
            bus.bresp   <= 1'b0;
            aw_id       <= '0;
            w_addr      <= '0;
            aw_len      <= '0;
            aw_size     <= '0;
            aw_burst    <= '0;
            w_beat      <= '0;
            w_err       <= 1'b0;
        end else begin
            w_state     <= w_next;
            bus.awready <= (w_next == W_IDLE);
            bus.wready  <= (w_next == W_DATA);
            bus.bvalid  <= (w_next == W_RESP);
            if (aw_hs) begin
                aw_id    <= bus.awid;
                w_addr   <= bus.awaddr;
                aw_len   <= bus.awlen;
                aw_size  <= bus.awsize;
                aw_burst <= bus.awburst;
                w_beat   <= '0;
                w_err    <= 1'b0;
            end
            if (w_hs) begin
                w_beat <= w_beat + 4'd1;
                w_addr <= next_addr(w_addr, aw_size, aw_burst, aw_len);
                w_err  <= w_err | w_beat_err;
                if (w_beat == aw_len) begin
                    bus.bid   <= aw_id;
                    bus.bresp <= w_err | w_beat_err;
                end
            end
        end
    end

    // Memory has no reset; nonblocking write keeps same-cycle reads returning old data.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (bus.wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, f_addr;
    logic [3:0]            r_len, r_beat, f_len, f_beat;
    logic [2:0]            r_size, f_size;
    logic [1:0]            r_burst, f_burst;
    logic                  ar_hs, r_hs, r_fetch, f_err;

    assign ar_hs = bus.arvalid && bus.arready;
    assign r_hs  = bus.rvalid && bus.rready;

    // f_* describe the beat to load into the output registers this cycle, if any.
    always_comb begin
        r_next  = r_state;
        r_fetch = 1'b0;
        f_addr  = next_addr(r_addr, r_size, r_burst, r_len);
        f_size  = r_size;
        f_burst = r_burst;
        f_len   = r_len;
        f_beat  = r_beat + 4'd1;
        if (r_state == R_IDLE) begin
            if (ar_hs) begin
                r_next  = R_DATA;
                r_fetch = 1'b1;
                f_addr  = bus.araddr;
                f_size  = bus.arsize;
                f_burst = bus.arburst;
                f_len   = bus.arlen;
                f_beat  = '0;
            end
        end else if (r_hs) begin
            if (r_beat == r_len) r_next = R_IDLE;
            else                 r_fetch = 1'b1;
        end
        f_err = burst_bad(f_size, f_burst, f_len) || (f_addr >= MEM_BYTES);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rresp   <= 1'b0;
            bus.rid     <= '0;
            bus.rdata   <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_size      <= '0;
            r_burst     <= '0;
        end else begin
            r_state     <= r_next;
            bus.arready <= (r_next == R_IDLE);
            bus.rvalid  <= (r_next == R_DATA);
            if (ar_hs) begin
                bus.rid <= bus.arid;
                r_size  <= bus.arsize;
                r_burst <= bus.arburst;
                r_len   <= bus.arlen;
            end
            if (r_fetch) begin
                r_addr    <= f_addr;
                r_beat    <= f_beat;
                bus.rdata <= f_err ? '0 : mem[word_idx(f_addr)];
                bus.rresp <= f_err;
                bus.rlast <= (f_beat == f_len);
            end else if (r_next == R_IDLE) begin
                bus.rlast <= 1'b0;
            end
        end
    end
endmodule
